// File: rtl/didactic_uart_rx_fifo.sv
// didactic_uart_rx_fifo: 8N1 UART receiver (synchroniser, oversampling FSM) feeding a valid/ready byte FIFO
module didactic_uart_rx_fifo #(
  parameter int ClkDivider = 868,
  parameter int FifoDepth  = 16,
  parameter int SyncStages = 2
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic                           uart_rx,
  input  logic                           clear_i,
  output logic [7:0]                     data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic                           frame_err_o,
  output logic                           overflow_o,
  output logic [$clog2(FifoDepth+1)-1:0] fill_o
);
  localparam int DW = $clog2(ClkDivider);
  localparam int AW = $clog2(FifoDepth);
  localparam int FW = $clog2(FifoDepth + 1);
  localparam logic [DW-1:0] BIT_LAST  = DW'(ClkDivider - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(ClkDivider / 2 - 1);
  localparam logic [FW-1:0] FULL      = FW'(FifoDepth);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic [SyncStages-1:0] sync;
  logic [DW-1:0] div;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] mem [FifoDepth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic rxs, tick, push, err, pop, full, accept;
  assign rxs     = sync[SyncStages-1];
  assign tick    = div == (state == START ? HALF_LAST : BIT_LAST);
  assign push    = state == STOP && tick && rxs;
  assign err     = state == STOP && tick && !rxs;
  assign valid_o = fill_o != '0;
  assign full    = fill_o == FULL;
  assign pop     = valid_o && ready_i;
  assign accept  = push && (!full || pop);
  assign data_o  = mem[rd_ptr];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = rxs ? IDLE : START;
      START:   state_n = !tick ? START : rxs ? IDLE : DATA;
      DATA:    state_n = tick && bit_cnt == 3'd7 ? STOP : DATA;
      STOP:    state_n = !tick ? STOP : rxs ? IDLE : BRK;
      BRK:     state_n = rxs ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      sync        <= '1;
      state       <= IDLE;
      div         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      sync        <= {sync[SyncStages-2:0], uart_rx};
      state       <= state_n;
      div         <= (state == IDLE || state == BRK || tick) ? '0 : div + 1'b1;
      bit_cnt     <= state == DATA ? bit_cnt + 3'(tick) : '0;
      shift       <= state == DATA && tick ? {rxs, shift[7:1]} : shift;
      frame_err_o <= err;
    end
  end
  // clear_i wins over a same-cycle push; the receive FSM above is untouched by it
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      mem        <= '{default: '0};
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_o     <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_o     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fill_o <= fill_o + FW'(accept) - FW'(pop);
      if (push && full && !pop) overflow_o <= 1'b1;
    end
  end
endmodule
